pipeline_latealu: RTL

PIPELINE_LATEALU -- requirements
Module: pipeline_latealu

---
 rtl/pipeline_latealu_pkg.sv | 29 ++
 rtl/pipeline_latealu_if.sv | 35 +++
 rtl/pipeline_latealu_mult_iter.sv | 67 ++++++
 rtl/pipeline_latealu.sv | 91 +++++++++
 4 files changed

// File: rtl/pipeline_latealu_pkg.sv
// Shared definitions for the late-ALU pipeline stage: op codes, exception
// codes, multiplier FSM encoding and a magnitude helper.
package pipeline_latealu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_SRL  = 6'd2;
    localparam logic [5:0] OP_SRA  = 6'd3;
    localparam logic [5:0] OP_MULT = 6'd4;
    localparam logic [5:0] OP_MTHI = 6'd5;
    localparam logic [5:0] OP_MTLO = 6'd6;

    localparam logic [2:0] EXC_NONE     = 3'b000;
    localparam logic [2:0] EXC_BAD_OP   = 3'b001;
    localparam logic [2:0] EXC_OVERFLOW = 3'b010;
    localparam logic [2:0] EXC_SYSCALL  = 3'b011;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_FIX  = 2'd2
    } mult_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/pipeline_latealu_if.sv
// Bus between the ALU stage and the late-ALU stage, plus the HI/LO and busy
// signals the hazard unit consumes.
interface pipeline_latealu_if;
    import pipeline_latealu_pkg::*;

    logic              latealu_enable;
    logic [5:0]        latealu_op;
    logic [DATA_W-1:0] latealu_a0;
    logic [DATA_W-1:0] latealu_a1;
    logic [4:0]        rd_index_in;
    logic [DATA_W-1:0] rd_value_in;
    logic [2:0]        exception_in;

    logic [4:0]        rd_index;
    logic [DATA_W-1:0] rd_value;
    logic [2:0]        exception;
    logic [DATA_W-1:0] latealu_mult_hi;
    logic [DATA_W-1:0] latealu_mult_lo;
    logic              mult_busy;

    modport master (
        output latealu_enable, latealu_op, latealu_a0, latealu_a1,
               rd_index_in, rd_value_in, exception_in,
        input  rd_index, rd_value, exception,
               latealu_mult_hi, latealu_mult_lo, mult_busy
    );

    modport slave (
        input  latealu_enable, latealu_op, latealu_a0, latealu_a1,
               rd_index_in, rd_value_in, exception_in,
        output rd_index, rd_value, exception,
               latealu_mult_hi, latealu_mult_lo, mult_busy
    );

endinterface

// File: rtl/pipeline_latealu_mult_iter.sv
// Iterative signed 32x32 multiplier: one shift-add step per cycle on operand
// magnitudes, then a single sign-fix cycle that registers the 64-bit product.
module latealu_mult_iter
    import pipeline_latealu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    mult_state_e         state;
    logic [4:0]          count;
    logic                neg;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W:0]     sum;

    assign sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mcand};
    assign busy = (state != MULT_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MULT_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else if (start) begin
            state <= MULT_RUN;
            count <= '0;
            done  <= 1'b0;
        end else if (abort) begin
            state <= MULT_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                MULT_RUN: begin
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= MULT_FIX;
                end
                MULT_FIX: begin
                    state <= MULT_IDLE;
                    done  <= 1'b1;
                end
                default: done <= 1'b0;
            endcase
        end
    end

    // Low half of acc starts as the multiplier and is consumed one bit per step.
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= {{DATA_W{1'b0}}, magnitude(b)};
            mcand <= magnitude(a);
            neg   <= a[DATA_W-1] ^ b[DATA_W-1];
        end else if (state == MULT_RUN) begin
            acc <= acc[0] ? {sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
        end else if (state == MULT_FIX) begin
            product <= neg ? (~acc + 1'b1) : acc;
        end
    end

endmodule

// File: rtl/pipeline_latealu.sv
// Late-ALU pipeline stage: shifts, HI/LO moves and an iterative multiply whose
// result lands in HI/LO atomically.
module pipeline_latealu
    import pipeline_latealu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pipeline_latealu_if.slave  bus
);

    logic [4:0]          rd_index_p0, rd_index_p1;
    logic [DATA_W-1:0]   rd_value_p0, rd_value_p1;
    logic [2:0]          exc_p0, exc_p1;
    logic [DATA_W-1:0]   hi_p1, lo_p1;
    logic                busy_p1;
    logic                start, wr_hi, wr_lo, abort, load_prod;
    logic                iter_busy, iter_done;
    logic [2*DATA_W-1:0] iter_product;

    function automatic logic [DATA_W-1:0] shift_right(input logic signed [DATA_W-1:0] v,
                                                      input logic [4:0] sh,
                                                      input logic arith);
        if (arith) return $unsigned(v >>> sh);
        return $unsigned(v) >> sh;
    endfunction

    // A pending exception from the ALU stage suppresses the late op entirely.
    always_comb begin
        rd_index_p0 = bus.rd_index_in;
        rd_value_p0 = bus.rd_value_in;
        exc_p0      = bus.exception_in;
        start       = 1'b0;
        wr_hi       = 1'b0;
        wr_lo       = 1'b0;
        if (bus.exception_in == EXC_NONE && bus.latealu_enable) begin
            case (bus.latealu_op)
                OP_SRL:  rd_value_p0 = shift_right(bus.latealu_a0, bus.latealu_a1[4:0], 1'b0);
                OP_SRA:  rd_value_p0 = shift_right(bus.latealu_a0, bus.latealu_a1[4:0], 1'b1);
                OP_MULT: begin rd_index_p0 = '0; start = 1'b1; end
                OP_MTHI: begin rd_index_p0 = '0; wr_hi = 1'b1; end
                OP_MTLO: begin rd_index_p0 = '0; wr_lo = 1'b1; end
                default: begin rd_index_p0 = '0; exc_p0 = EXC_BAD_OP; end
            endcase
        end
    end

    assign abort     = wr_hi | wr_lo;
    assign load_prod = iter_done && !iter_busy && busy_p1 && !start && !abort;

    latealu_mult_iter u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (bus.latealu_a0),
        .b       (bus.latealu_a1),
        .busy    (iter_busy),
        .done    (iter_done),
        .product (iter_product)
    );

    // p0 -> p1: writeback, exception and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_index_p1 <= '0;
            rd_value_p1 <= '0;
            exc_p1      <= '0;
            hi_p1       <= '0;
            lo_p1       <= '0;
            busy_p1     <= 1'b0;
        end else begin
            rd_index_p1 <= rd_index_p0;
            rd_value_p1 <= rd_value_p0;
            exc_p1      <= exc_p0;
            if (wr_hi)          hi_p1 <= bus.latealu_a0;
            else if (load_prod) hi_p1 <= iter_product[2*DATA_W-1:DATA_W];
            if (wr_lo)          lo_p1 <= bus.latealu_a0;
            else if (load_prod) lo_p1 <= iter_product[DATA_W-1:0];
            if (start)                   busy_p1 <= 1'b1;
            else if (abort || load_prod) busy_p1 <= 1'b0;
        end
    end

    assign bus.rd_index        = rd_index_p1;
    assign bus.rd_value        = rd_value_p1;
    assign bus.exception       = exc_p1;
    assign bus.latealu_mult_hi = hi_p1;
    assign bus.latealu_mult_lo = lo_p1;
    assign bus.mult_busy       = busy_p1;

endmodule
